// File: rtl/multi_port_mem_ctrl_if.sv
// Requester-side bundle: per-port request fields flattened per port, shared response.
// Latency: none, wiring only.
// Backpressure: a requester holds req_en until its rsp_rdy pulse.
interface multi_port_mem_ctrl_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]    req_en;
  logic [32*NUM_PORTS-1:0] req_addr;
  logic [2*NUM_PORTS-1:0]  req_size;
  logic [NUM_PORTS-1:0]    req_wr;
  logic [NUM_PORTS-1:0]    req_sign;
  logic [32*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]    rsp_rdy;
  logic [31:0]             rsp_data;

  modport master (
    output req_en, req_addr, req_size, req_wr, req_sign, req_wdata,
    input  rsp_rdy, rsp_data
  );

  modport slave (
    input  req_en, req_addr, req_size, req_wr, req_sign, req_wdata,
    output rsp_rdy, rsp_data
  );
endinterface

// File: rtl/multi_port_mem_ctrl.sv
// Arbitrates NUM_PORTS requesters onto one byte-serial RAM/IO bus, 1/2/4-byte reads and writes.
// Latency: accept to rsp_rdy = n+1 edges; back-to-back accepts spaced n+3 edges.
// Backpressure: rdy_in=0 or io_buffer_full=1 freezes every register; flush aborts maskable reads.
module multi_port_mem_ctrl #(
  parameter int                   NUM_PORTS  = 3,
  parameter bit                   RR_MODE    = 1'b1,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 3'b011
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   io_buffer_full,
  input  logic                   flush,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  multi_port_mem_ctrl_if.slave   bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                 state_q, state_nxt;
  logic [PW-1:0]          port_q, port_nxt;
  logic [PW-1:0]          rr_q, rr_nxt;
  logic [2:0]             n_q, n_nxt;
  logic [2:0]             cnt_q, cnt_nxt;
  logic                   wr_q, wr_nxt;
  logic                   sign_q, sign_nxt;
  logic [31:0]            wdata_q, wdata_nxt;
  logic [31:0]            rd_buf_q, rd_buf_nxt;
  logic [31:0]            mem_a_nxt;
  logic [7:0]             mem_dout_nxt;
  logic                   mem_wr_nxt;
  logic [NUM_PORTS-1:0]   rsp_rdy_q, rsp_rdy_nxt;
  logic [31:0]            rsp_data_q, rsp_data_nxt;

  logic                   gnt_vld;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          cand;
  logic [7:0]             wbyte;
  logic [31:0]            rd_word;
  logic [31:0]            rd_ext;
  logic                   run_en;

  logic [31:0]            addr_arr  [NUM_PORTS];
  logic [31:0]            wdata_arr [NUM_PORTS];
  logic [1:0]             size_arr  [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = bus.req_addr[32*p +: 32];
    assign wdata_arr[p] = bus.req_wdata[32*p +: 32];
    assign size_arr[p]  = bus.req_size[2*p +: 2];
  end

  assign run_en       = rdy_in && !io_buffer_full;
  assign bus.rsp_rdy  = rsp_rdy_q;
  assign bus.rsp_data = rsp_data_q;

  // Size code 3 is an alias of 4 bytes.
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Grant search: scan from the rr pointer (or from 0 in fixed mode); the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      int pos;
      pos = k + (RR_MODE ? int'(rr_q) : 0);
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      cand = PW'(pos);
      if (bus.req_en[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Byte datapath: outgoing write byte, read word with the byte arriving this edge merged in, extension.
  always_comb begin
    wbyte   = 8'h00;
    rd_word = rd_buf_q;
    for (int b = 0; b < 4; b++) begin
      if (cnt_q == 3'(b)) wbyte = wdata_q[8*b +: 8];
      if (cnt_q == 3'(b + 2)) rd_word[8*b +: 8] = mem_din;
    end
    case (n_q)
      3'd1:    rd_ext = sign_q ? {{24{rd_word[7]}}, rd_word[7:0]}   : {24'h0, rd_word[7:0]};
      3'd2:    rd_ext = sign_q ? {{16{rd_word[15]}}, rd_word[15:0]} : {16'h0, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // Next-state and next-output logic; every register holds unless a branch below moves it.
  always_comb begin
    state_nxt    = state_q;
    port_nxt     = port_q;
    rr_nxt       = rr_q;
    n_nxt        = n_q;
    cnt_nxt      = cnt_q;
    wr_nxt       = wr_q;
    sign_nxt     = sign_q;
    wdata_nxt    = wdata_q;
    rd_buf_nxt   = rd_buf_q;
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    mem_wr_nxt   = mem_wr;
    rsp_rdy_nxt  = rsp_rdy_q;
    rsp_data_nxt = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          port_nxt     = gnt_idx;
          n_nxt        = size_bytes(size_arr[gnt_idx]);
          wr_nxt       = bus.req_wr[gnt_idx];
          sign_nxt     = bus.req_sign[gnt_idx];
          wdata_nxt    = wdata_arr[gnt_idx];
          rd_buf_nxt   = '0;
          mem_a_nxt    = addr_arr[gnt_idx];
          mem_wr_nxt   = bus.req_wr[gnt_idx];
          mem_dout_nxt = wdata_arr[gnt_idx][7:0];
          cnt_nxt      = 3'd1;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        cnt_nxt = cnt_q + 3'd1;
        if (cnt_q < n_q) begin
          mem_a_nxt = mem_a + 32'd1;
          if (wr_q) begin
            mem_dout_nxt = wbyte;
            mem_wr_nxt   = 1'b1;
          end
        end else begin
          mem_wr_nxt = 1'b0;
        end
        // Read bytes land two edges after their address because of the RAM's registered output.
        if (!wr_q && cnt_q >= 3'd2) rd_buf_nxt = rd_word;
        if (cnt_q == n_q + 3'd1) begin
          rsp_rdy_nxt          = '0;
          rsp_rdy_nxt[port_q]  = 1'b1;
          rsp_data_nxt         = wr_q ? 32'h0 : rd_ext;
          state_nxt            = DONE;
        end
      end
      DONE: begin
        rsp_rdy_nxt = '0;
        rr_nxt      = (port_q == PW'(NUM_PORTS - 1)) ? '0 : port_q + 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Flush drops an in-flight read from a maskable port, including one about to respond.
    if (flush && state_q != IDLE && !wr_q && FLUSH_MASK[port_q]) begin
      state_nxt   = IDLE;
      rsp_rdy_nxt = '0;
      mem_wr_nxt  = 1'b0;
      rr_nxt      = rr_q;
    end
  end

  // State register; a stall freezes everything, reset clears bus outputs asynchronously.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      port_q     <= '0;
      rr_q       <= '0;
      n_q        <= 3'd1;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      sign_q     <= 1'b0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      rsp_rdy_q  <= '0;
      rsp_data_q <= '0;
    end else if (run_en) begin
      state_q    <= state_nxt;
      port_q     <= port_nxt;
      rr_q       <= rr_nxt;
      n_q        <= n_nxt;
      cnt_q      <= cnt_nxt;
      wr_q       <= wr_nxt;
      sign_q     <= sign_nxt;
      wdata_q    <= wdata_nxt;
      rd_buf_q   <= rd_buf_nxt;
      mem_a      <= mem_a_nxt;
      mem_dout   <= mem_dout_nxt;
      mem_wr     <= mem_wr_nxt;
      rsp_rdy_q  <= rsp_rdy_nxt;
      rsp_data_q <= rsp_data_nxt;
    end
  end

endmodule
